// File: rtl/perf_trace_logger_if.sv
// Byte-stream link between perf_trace_logger and the shared UART TX module.
interface perf_trace_logger_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, output tx_done, input tx_busy);
  modport slave  (input tx_start, input tx_data, input tx_done, output tx_busy);
endinterface

// File: rtl/perf_trace_logger.sv
// Samples core/FIFO/divider state into a ring buffer and streams a framed dump over UART TX.
// Optional feature macro: PERF_LOG_TIMESTAMP_EN (adds a per-entry TS_W-bit cycle stamp).
module perf_trace_logger #(
  parameter int NUM_CORES = 4,
  parameter int NUM_FIFOS = 3,
  parameter int LOAD_W    = 3,
  parameter int DIV_W     = 4,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 9,
  parameter int TS_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        log_en,
  input  logic                        tx_req,
  input  logic [15:0]                 interval,
  input  logic                        wrap_mode,
  input  logic [NUM_CORES-1:0]        core_busy,
  input  logic [NUM_FIFOS*LOAD_W-1:0] fifo_load,
  input  logic [NUM_CORES*DIV_W-1:0]  core_div,
  perf_trace_logger_if.master         tx,
  output logic                        overflow,
  output logic                        busy
);

  localparam int RAW_W    = NUM_CORES + NUM_FIFOS * LOAD_W + NUM_CORES * DIV_W;
  localparam int PB       = (RAW_W + 7) / 8;
  localparam int PAY_BITS = PB * 8;
  localparam int PAD_BITS = PAY_BITS - RAW_W;
`ifdef PERF_LOG_TIMESTAMP_EN
  localparam logic TS_EN  = 1'b1;
`else
  localparam logic TS_EN  = 1'b0;
`endif
  localparam int TSB      = (TS_W + 7) / 8;
  localparam int EB       = PB + (TS_EN ? TSB : 0);
  localparam int ENT_BITS = EB * 8;
  localparam int CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOG   = 3'd1,
    S_HDR   = 3'd2,
    S_FETCH = 3'd3,
    S_DATA  = 3'd4,
    S_FTR   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_r;
  logic [ENT_BITS-1:0] mem_r [DEPTH];
  logic [ENT_BITS-1:0] rd_data_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    ent_cnt_r;
  logic [15:0]         smp_cnt_r;
  logic [7:0]          byte_idx_r;
  logic                wrap_r;
  logic                overflow_r;
  logic                busy_r;
  logic                tx_start_r;
  logic [7:0]          tx_data_r;
  logic                tx_done_r;
`ifdef PERF_LOG_TIMESTAMP_EN
  logic [TS_W-1:0]     ts_r;
`endif

  logic [PAY_BITS-1:0] payload_s;
  logic [ENT_BITS-1:0] wr_data_s;
  logic [ENT_BITS-1:0] sh_s;
  logic [15:0]         sh_amt_s;
  logic [15:0]         iv_last_s;
  logic [15:0]         cnt16_s;
  logic [ADDR_W-1:0]   wr_ptr_nx_s;
  logic [ADDR_W-1:0]   rd_ptr_nx_s;
  logic [CNT_W-1:0]    ent_nx_s;
  logic [7:0]          hdr_byte_s;
  logic [7:0]          ftr_byte_s;
  logic [7:0]          data_byte_s;
  logic                sample_hit_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                can_send_s;

  // Entry assembly, sample-point detect, pointer arithmetic and outgoing byte muxes.
  always_comb begin
    payload_s    = PAY_BITS'({core_busy, fifo_load, core_div}) << PAD_BITS;
`ifdef PERF_LOG_TIMESTAMP_EN
    wr_data_s    = {(TSB * 8)'(ts_r), payload_s};
`else
    wr_data_s    = payload_s;
`endif
    iv_last_s    = (interval == 16'd0) ? 16'd0 : interval - 16'd1;
    sample_hit_s = (state_r == S_LOG) && (smp_cnt_r == iv_last_s);
    // Stop mode drops samples once full; wrap mode always overwrites.
    wr_en_s      = sample_hit_s && (wrap_r || (count_r != FULL));
    rd_en_s      = (state_r == S_FETCH);
    can_send_s   = !tx.tx_busy && !tx_start_r;
    wr_ptr_nx_s  = (wr_ptr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : wr_ptr_r + ADDR_W'(1);
    rd_ptr_nx_s  = (rd_ptr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : rd_ptr_r + ADDR_W'(1);
    ent_nx_s     = ent_cnt_r + CNT_W'(1);
    cnt16_s      = 16'(count_r);
    sh_amt_s     = 16'(EB - 1) - 16'(byte_idx_r);
    sh_s         = rd_data_r >> {sh_amt_s, 3'b000};
    data_byte_s  = sh_s[7:0];
    case (byte_idx_r[2:0])
      3'd0:    hdr_byte_s = 8'h4C;
      3'd1:    hdr_byte_s = 8'h4F;
      3'd2:    hdr_byte_s = 8'h47;
      3'd3:    hdr_byte_s = 8'h3A;
      3'd4:    hdr_byte_s = cnt16_s[15:8];
      3'd5:    hdr_byte_s = cnt16_s[7:0];
      3'd6:    hdr_byte_s = {5'b00000, TS_EN, wrap_r, overflow_r};
      3'd7:    hdr_byte_s = 8'(EB);
      default: hdr_byte_s = 8'h00;
    endcase
    case (byte_idx_r[1:0])
      2'd0:    ftr_byte_s = 8'h45;
      2'd1:    ftr_byte_s = 8'h4E;
      2'd2:    ftr_byte_s = 8'h44;
      2'd3:    ftr_byte_s = 8'h0A;
      default: ftr_byte_s = 8'h00;
    endcase
  end

  // Ring buffer storage: synchronous write while logging, synchronous read in FETCH.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_ptr_r];
    end
  end

  // Control FSM: capture session, framed dump and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ent_cnt_r  <= {CNT_W{1'b0}};
      smp_cnt_r  <= 16'd0;
      byte_idx_r <= 8'd0;
      wrap_r     <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_done_r  <= 1'b0;
`ifdef PERF_LOG_TIMESTAMP_EN
      ts_r       <= {TS_W{1'b0}};
`endif
    end else begin
      tx_start_r <= 1'b0;
      tx_done_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (log_en) begin
            state_r    <= S_LOG;
            busy_r     <= 1'b1;
            wr_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            smp_cnt_r  <= 16'd0;
            overflow_r <= 1'b0;
            wrap_r     <= wrap_mode;
`ifdef PERF_LOG_TIMESTAMP_EN
            ts_r       <= {TS_W{1'b0}};
`endif
          end else if (tx_req) begin
            state_r   <= S_HDR;
            busy_r    <= 1'b1;
            ent_cnt_r <= {CNT_W{1'b0}};
            // A full wrap-mode buffer starts at its oldest entry, which is the next write slot.
            rd_ptr_r  <= (wrap_r && (count_r == FULL)) ? wr_ptr_r : {ADDR_W{1'b0}};
            if (!tx.tx_busy) begin
              tx_start_r <= 1'b1;
              tx_data_r  <= 8'h4C;
              byte_idx_r <= 8'd1;
            end else begin
              byte_idx_r <= 8'd0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOG: begin
          smp_cnt_r <= sample_hit_s ? 16'd0 : smp_cnt_r + 16'd1;
`ifdef PERF_LOG_TIMESTAMP_EN
          ts_r      <= ts_r + TS_W'(1);
`endif
          if (sample_hit_s) begin
            if (count_r == FULL) begin
              overflow_r <= 1'b1;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
          if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_nx_s;
          end
          if (!log_en) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_HDR: begin
          if (can_send_s) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= hdr_byte_s;
            if (byte_idx_r == 8'd7) begin
              byte_idx_r <= 8'd0;
              state_r    <= (count_r == {CNT_W{1'b0}}) ? S_FTR : S_FETCH;
            end else begin
              byte_idx_r <= byte_idx_r + 8'd1;
            end
          end
        end
        S_FETCH: begin
          byte_idx_r <= 8'd0;
          state_r    <= S_DATA;
        end
        S_DATA: begin
          if (can_send_s) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= data_byte_s;
            if (byte_idx_r == 8'(EB - 1)) begin
              byte_idx_r <= 8'd0;
              rd_ptr_r   <= rd_ptr_nx_s;
              ent_cnt_r  <= ent_nx_s;
              state_r    <= (ent_nx_s == count_r) ? S_FTR : S_FETCH;
            end else begin
              byte_idx_r <= byte_idx_r + 8'd1;
            end
          end
        end
        S_FTR: begin
          if (can_send_s) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= ftr_byte_s;
            if (byte_idx_r == 8'd3) begin
              byte_idx_r <= 8'd0;
              state_r    <= S_DONE;
            end else begin
              byte_idx_r <= byte_idx_r + 8'd1;
            end
          end
        end
        S_DONE: begin
          tx_done_r <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign tx.tx_start = tx_start_r;
  assign tx.tx_data  = tx_data_r;
  assign tx.tx_done  = tx_done_r;
  assign overflow    = overflow_r;
  assign busy        = busy_r;

endmodule
